muldiv_unit: RTL and testbench

//  Iterative RV64M multiply/divide unit; consumes rs1_data/rs2_data from register_file.

---
 rtl/muldiv_unit.sv | 197 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with the
// sign fixed up on the final step. Divide-by-zero and signed overflow finish
// immediately without iterating. The core is stalled while an operation runs.
// Optional feature macro: MULDIV_WORD_OPS_EN enables the OP-32 (word) forms.
// Without it the word input is ignored and every op is 64-bit.
module muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam int unsigned HALF = XLEN / 2;
  localparam int unsigned PW   = 2 * XLEN;
  localparam int unsigned CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic            word_q;
  logic            a_neg_q;
  logic            b_neg_q;
  logic [XLEN-1:0] mag_a_q;
  logic [XLEN-1:0] mag_b_q;
  logic [XLEN-1:0] shf_q;
  logic [XLEN-1:0] rem_q;
  logic [PW-1:0]   acc_q;

  logic            word_op;
  logic            a_sgn;
  logic            b_sgn;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            div_ovf;
  logic [XLEN-1:0] spec_res;

  logic [PW-1:0]   acc_nxt;
  logic [XLEN:0]   r_sh;
  logic            ge;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] shf_nxt;
  logic [PW-1:0]   prod;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rmd;
  logic [XLEN-1:0] fin_res;

`ifdef MULDIV_WORD_OPS_EN
  assign word_op = word;
`else
  logic unused_word;
  assign unused_word = word;
  assign word_op     = 1'b0;
`endif

  // Sign-extend the low half to a full-width value.
  function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  // Word results are the sign-extended low half; full-width results pass through.
  function automatic logic [XLEN-1:0] fix_word(input logic w, input logic [XLEN-1:0] x);
    return w ? sext_w(x[HALF-1:0]) : x;
  endfunction

  // Core stalls while a new request is being taken or an operation iterates.
  assign stall = ((state_q == IDLE) && start) || (state_q == BUSY);

  // Operand decode: signedness, extension, magnitudes and the early-out cases.
  always_comb begin
    a_sgn    = !op[2] ? (op[1:0] != 2'b11) : !op[0];
    b_sgn    = !op[2] ? !op[1] : !op[0];
    a_ext    = word_op ? {{HALF{a_sgn & rs1_data[HALF-1]}}, rs1_data[HALF-1:0]} : rs1_data;
    b_ext    = word_op ? {{HALF{b_sgn & rs2_data[HALF-1]}}, rs2_data[HALF-1:0]} : rs2_data;
    a_neg    = a_sgn & a_ext[XLEN-1];
    b_neg    = b_sgn & b_ext[XLEN-1];
    mag_a    = a_neg ? (XLEN'(0) - a_ext) : a_ext;
    mag_b    = b_neg ? (XLEN'(0) - b_ext) : b_ext;
    div_zero = op[2] && (b_ext == XLEN'(0));
    div_ovf  = op[2] && !op[0] && (b_ext == {XLEN{1'b1}}) &&
               (word_op ? (a_ext == {{(HALF + 1){1'b1}}, {(HALF - 1){1'b0}}})
                        : (a_ext == {1'b1, {(XLEN - 1){1'b0}}}));
    spec_res = '0;
    if (div_zero) begin
      spec_res = op[1] ? a_ext : {XLEN{1'b1}};
    end else if (div_ovf) begin
      spec_res = op[1] ? XLEN'(0) : a_ext;
    end
    spec_res = fix_word(word_op, spec_res);
  end

  // One radix-2 step plus the sign/width fix-up applied on the last step.
  always_comb begin
    acc_nxt = (acc_q << 1) + (shf_q[XLEN-1] ? {{XLEN{1'b0}}, mag_a_q} : PW'(0));
    r_sh    = {rem_q, shf_q[XLEN-1]};
    ge      = r_sh >= {1'b0, mag_b_q};
    rem_nxt = ge ? XLEN'(r_sh - {1'b0, mag_b_q}) : r_sh[XLEN-1:0];
    shf_nxt = (shf_q << 1) | XLEN'(op_q[2] & ge);
    prod    = (a_neg_q ^ b_neg_q) ? (PW'(0) - acc_nxt) : acc_nxt;
    quo     = (a_neg_q ^ b_neg_q) ? (XLEN'(0) - shf_nxt) : shf_nxt;
    rmd     = a_neg_q ? (XLEN'(0) - rem_nxt) : rem_nxt;
    if (op_q[2]) begin
      fin_res = fix_word(word_q, op_q[1] ? rmd : quo);
    end else if (word_q) begin
      fin_res = (op_q[1:0] == 2'b00) ? sext_w(prod[HALF-1:0]) : XLEN'(0);
    end else begin
      fin_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
    end
  end

  // Control FSM and datapath registers; result and valid are registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      shf_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      valid   <= 1'b0;
      result  <= '0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            word_q  <= word_op;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            mag_a_q <= mag_a;
            mag_b_q <= mag_b;
            acc_q   <= '0;
            rem_q   <= '0;
            // Left-align the shifted operand so its MSB is always the bit consumed.
            if (op[2]) begin
              shf_q <= word_op ? {mag_a[HALF-1:0], HALF'(0)} : mag_a;
            end else begin
              shf_q <= word_op ? {mag_b[HALF-1:0], HALF'(0)} : mag_b;
            end
            if (div_zero || div_ovf) begin
              cnt_q   <= '0;
              result  <= spec_res;
              valid   <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= word_op ? CW'(HALF) : CW'(XLEN);
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          acc_q <= acc_nxt;
          rem_q <= rem_nxt;
          shf_q <= shf_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result  <= fin_res;
            valid   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed-vector bench for muldiv_unit. Expected results and
// latencies are hand-computed; word-form expectations follow MULDIV_WORD_OPS_EN.
module tb_muldiv_unit;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        word;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        stall;
  logic        valid;
  logic [63:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

`ifdef MULDIV_WORD_OPS_EN
  localparam int          WLAT      = 33;
  localparam logic [63:0] DIVW_EXP  = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] MULW_EXP  = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] MULHUW_EXP = 64'h0;
  localparam int          REMUW_LAT = 1;
  localparam logic [63:0] REMUW_EXP = 64'hFFFF_FFFF_9ABC_DEF0;
`else
  localparam int          WLAT      = 65;
  localparam logic [63:0] DIVW_EXP  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MULW_EXP  = 64'h0000_0000_FFFF_FFFE;
  localparam logic [63:0] MULHUW_EXP = 64'h1;
  localparam int          REMUW_LAT = 65;
  localparam logic [63:0] REMUW_EXP = 64'h1234_5678_9ABC_DEF0;
`endif

  muldiv_unit #(.XLEN(64)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .word     (word),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .stall    (stall),
    .valid    (valid),
    .result   (result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one instruction (start held until valid) and check latency, stall and result.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat);
    int   lat;
    logic stall_ok;
    lat      = 0;
    stall_ok = 1'b1;
    @(negedge clock);
    start    = 1'b1;
    op       = f3;
    word     = w;
    rs1_data = a;
    rs2_data = b;
    #1;
    check({tag, " stall_c0"}, 64'(stall), 64'd1);
    @(posedge clock);
    #1;
    rs1_data = {$urandom, $urandom};
    rs2_data = {$urandom, $urandom};
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (valid) begin
        lat = c;
        break;
      end
      if (!stall) stall_ok = 1'b0;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " stall_done"}, 64'(stall), 64'd0);
    check({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
    start = 1'b0;
  endtask

  initial begin
    logic seen_valid;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 3'b000;
    word     = 1'b0;
    rs1_data = '0;
    rs2_data = '0;
    repeat (3) @(negedge clock);
    check("reset stall", 64'(stall), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset result", result, 64'd0);
    reset = 1'b0;

    run_op("MUL 7*-3",     F_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("MULHU max*2",  F_MULHU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
    run_op("MULH -1*-1",   F_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65);
    run_op("MULHSU -1*2",  F_MULHSU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("MUL wide",     F_MUL,    1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 65);
    run_op("DIV -7/2",     F_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("REM -7%2",     F_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("DIV 100/-7",   F_DIV,    1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 65);
    run_op("DIVU max/16",  F_DIVU,   1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    run_op("REMU 100%7",   F_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65);
    run_op("DIVU 5/0",     F_DIVU,   1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("REM 5%0",      F_REM,    1'b0, 64'd5, 64'd0, 64'd5, 1);
    run_op("DIV ovf",      F_DIV,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    run_op("REM ovf",      F_REM,    1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("DIVW",         F_DIV,    1'b1, 64'h0000_0000_8000_0000, 64'd1, DIVW_EXP, WLAT);
    run_op("MULW",         F_MUL,    1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, MULW_EXP, WLAT);
    run_op("MULHU word",   F_MULHU,  1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, MULHUW_EXP, WLAT);
    run_op("REMUW by 0",   F_REMU,   1'b1, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_0000_0000, REMUW_EXP, REMUW_LAT);

    // Reset while BUSY aborts the operation with no valid pulse afterwards.
    @(negedge clock);
    start    = 1'b1;
    op       = F_MUL;
    word     = 1'b0;
    rs1_data = 64'd9;
    rs2_data = 64'd9;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clock);
    check("midrst stall", 64'(stall), 64'd0);
    check("midrst valid", 64'(valid), 64'd0);
    check("midrst result", result, 64'd0);
    reset      = 1'b0;
    seen_valid = 1'b0;
    repeat (80) begin
      @(negedge clock);
      if (valid) seen_valid = 1'b1;
    end
    check("midrst no_valid", 64'(seen_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
